chunked_borrow_subtractor: RTL and testbench

- Multi-cycle unsigned subtractor. Computes diff = a - b - b_in over WIDTH bits, CHUNK bits per cycle.
- The borrow is registered between chunks.
- Companion to the combinational carry-propagate adders in the arithmetic library; used where area matters more than latency.
- Valid/ready handshake on both operand input and result output.

---
 rtl/chunked_borrow_subtractor_if.sv | 27 ++
 rtl/chunked_borrow_subtractor.sv | 113 +++++++++++
 tb/tb_chunked_borrow_subtractor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/chunked_borrow_subtractor_if.sv
// Operand/result handshake bundle for chunked_borrow_subtractor.
// master: producer of operands and consumer of results (testbench or upstream).
// slave : the subtractor itself.
interface chunked_borrow_subtractor_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             b_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             b_out;
  logic             zero;

  modport master (
    output in_valid, a, b, b_in, out_ready,
    input  in_ready, out_valid, diff, b_out, zero
  );

  modport slave (
    input  in_valid, a, b, b_in, out_ready,
    output in_ready, out_valid, diff, b_out, zero
  );
endinterface

// File: rtl/chunked_borrow_subtractor.sv
// chunked_borrow_subtractor: multi-cycle unsigned diff = a - b - b_in.
// One CHUNK-bit slice is subtracted per RUN cycle, borrow carried in a register,
// so a WIDTH-bit result takes NCHUNK cycles plus accept and handoff.
// Optional build macro SUB_SATURATE_EN: an underflowing result (final borrow = 1)
// is reported as diff = 0, zero = 1, with b_out still 1.
module chunked_borrow_subtractor #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  chunked_borrow_subtractor_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef logic [NCHUNK-1:0][CHUNK-1:0] chunks_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("chunked_borrow_subtractor: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  state_t          state;
  chunks_t         a_q;
  chunks_t         b_q;
  chunks_t         diff_q;
  logic            borrow_q;
  logic [IDXW-1:0] idx;
  logic            out_valid_q;
  logic            b_out_q;
  logic            zero_q;

  logic [CHUNK:0]  chunk_res;
  chunks_t         diff_next;
  logic            last_chunk;

  // Current slice: (CHUNK+1)-bit subtract, MSB is the outgoing borrow.
  always_comb begin
    chunk_res      = {1'b0, a_q[idx]} - {1'b0, b_q[idx]} - {{CHUNK{1'b0}}, borrow_q};
    diff_next      = diff_q;
    diff_next[idx] = chunk_res[CHUNK-1:0];
    last_chunk     = (idx == IDXW'(NCHUNK - 1));
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.b_out     = b_out_q;
  assign bus.zero      = zero_q;

  // Control FSM plus datapath registers; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      idx         <= '0;
      out_valid_q <= 1'b0;
      b_out_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is implied here (IDLE and not in reset).
          if (bus.in_valid) begin
            a_q      <= bus.a;
            b_q      <= bus.b;
            borrow_q <= bus.b_in;
            idx      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff_q   <= diff_next;
          borrow_q <= chunk_res[CHUNK];
          if (last_chunk) begin
            idx         <= '0;
            state       <= DONE;
            out_valid_q <= 1'b1;
            b_out_q     <= chunk_res[CHUNK];
`ifdef SUB_SATURATE_EN
            if (chunk_res[CHUNK]) begin
              diff_q <= '0;
              zero_q <= 1'b1;
            end else begin
              zero_q <= (diff_next == '0);
            end
`else
            zero_q      <= (diff_next == '0);
`endif
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          // Result held until taken; a new operand waits for the next IDLE cycle.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_borrow_subtractor.sv
// Self-checking bench for chunked_borrow_subtractor (WIDTH=16, CHUNK=4).
module tb_chunked_borrow_subtractor;
  localparam int W = 16;
  localparam int C = 4;
  localparam int LAT = W / C + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunked_borrow_subtractor_if #(.WIDTH(W)) bus ();
  chunked_borrow_subtractor #(.WIDTH(W), .CHUNK(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] d;
    logic         bo;
    logic         z;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the whole operands.
  function automatic void ref_sub(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                                  output logic [W-1:0] d, output logic bo, output logic z);
    int sa, sb;
    sa = int'(a);
    sb = int'(b) + int'(bin);
    bo = (sa < sb);
    d  = W'(sa - sb);
`ifdef SUB_SATURATE_EN
    if (bo) d = '0;
`endif
    z = (d == '0);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one operand set, wait for the result, take it. Returns result and latency.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic z,
                       output int lat);
    int n;
    n = 0;
    while (!bus.in_ready && n < 20) begin tick(); n++; end
    chk("in_ready_wait", {31'b0, bus.in_ready}, 32'd1);
    bus.a = a; bus.b = b; bus.b_in = bin; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.b_in = 1'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin tick(); lat++; end
    d = bus.diff; bo = bus.b_out; z = bus.zero;
    chk("out_valid_seen", {31'b0, bus.out_valid}, 32'd1);
    tick();
    chk("out_valid_drop", {31'b0, bus.out_valid}, 32'd0);
  endtask

  logic [W-1:0] gd, ed, hd;
  logic         gbo, gz, ebo, ez, hbo, hz;
  int           lat;
  int           seen;

  initial begin
    vt[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
    vt[1] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    vt[2] = '{16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0};
`ifdef SUB_SATURATE_EN
    vt[2] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b1};
    vt[3] = '{16'h0000, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
`else
    vt[3] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
`endif
    vt[4] = '{16'hBEEF, 16'hBEEF, 1'b0, 16'h0000, 1'b0, 1'b1};
    vt[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.b_in = 1'b0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_diff", {16'b0, bus.diff}, 32'd0);
    chk("rst_b_out", {31'b0, bus.b_out}, 32'd0);
    chk("rst_zero", {31'b0, bus.zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // Directed vectors.
    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].bin, gd, gbo, gz, lat);
      chk($sformatf("vec%0d_diff", i), {16'b0, gd}, {16'b0, vt[i].d});
      chk($sformatf("vec%0d_b_out", i), {31'b0, gbo}, {31'b0, vt[i].bo});
      chk($sformatf("vec%0d_zero", i), {31'b0, gz}, {31'b0, vt[i].z});
      chk($sformatf("vec%0d_latency", i), lat, LAT);
    end

    // Backpressure: result must hold while busy inputs are ignored.
    bus.out_ready = 1'b0;
    bus.a = 16'h4321; bus.b = 16'h1111; bus.b_in = 1'b1; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin tick(); lat++; end
    chk("bp_latency", lat, LAT);
    ref_sub(16'h4321, 16'h1111, 1'b1, ed, ebo, ez);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1; bus.a = W'($urandom); bus.b = W'($urandom); bus.b_in = 1'($urandom);
      tick();
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_diff", {16'b0, bus.diff}, {16'b0, ed});
      chk("bp_b_out", {31'b0, bus.b_out}, {31'b0, ebo});
      chk("bp_zero", {31'b0, bus.zero}, {31'b0, ez});
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    chk("bp_release_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("bp_release_ready", {31'b0, bus.in_ready}, 32'd1);
    do_op(16'h8000, 16'h7FFF, 1'b0, gd, gbo, gz, lat);
    chk("bp_next_diff", {16'b0, gd}, 32'h0001);
    chk("bp_next_b_out", {31'b0, gbo}, 32'd0);

    // Reset at the second RUN cycle aborts the operation.
    bus.out_ready = 1'b1;
    bus.a = 16'h9999; bus.b = 16'h1111; bus.b_in = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("abort_rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("abort_diff", {16'b0, bus.diff}, 32'd0);
    chk("abort_b_out", {31'b0, bus.b_out}, 32'd0);
    chk("abort_zero", {31'b0, bus.zero}, 32'd0);
    rst = 1'b0;
    #1;
    chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    chk("abort_no_result", seen, 0);
    do_op(16'h0010, 16'h0001, 1'b0, gd, gbo, gz, lat);
    chk("abort_next_diff", {16'b0, gd}, 32'h000F);

    // Randomized operands against the reference.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rbin;
      ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      ref_sub(ra, rb, rbin, hd, hbo, hz);
      do_op(ra, rb, rbin, gd, gbo, gz, lat);
      chk($sformatf("rnd%0d_diff", i), {16'b0, gd}, {16'b0, hd});
      chk($sformatf("rnd%0d_b_out", i), {31'b0, gbo}, {31'b0, hbo});
      chk($sformatf("rnd%0d_zero", i), {31'b0, gz}, {31'b0, hz});
      chk($sformatf("rnd%0d_latency", i), lat, LAT);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
